hazard_forward_ctrl: RTL
========================

// Module: hazard_forward_ctrl
// PURPOSE
//  Parametrised forwarding and hazard controller for the pipelined core.
//  - Selects a bypass source for each EX-stage operand from NUM_FWD_STAGES in-flight stages.
//  - Detects load-use hazards and stalls the pipeline for them.
//  - Keeps a per-register scoreboard for a multi-cycle unit (mul/div) and schedules its
//    writeback slots, so long-latency results never collide on the register-file write port.
//  - Sits beside the ID/EX boundary. Drives the operand muxes, the IF/ID hold and the ID/EX bubble.
// PARAMETERS
//  NUM_SRC        2  source operands per instruction
//  REG_AW         5  register address width (2**REG_AW architectural regs)
//  NUM_FWD_STAGES 2  bypassable stages; index 0 = youngest (EX/MEM), 1 = MEM/WB, ...
//  MAX_LAT        8  maximum multi-cycle latency in cycles (>=2)
//  FWD_EN         1  1: bypass enabled; 0: every forwardable RAW becomes a stall
// PORTS
//  clk            in   1                     clock, rising edge
//  rst_n          in   1                     async active-low reset
//  stage_regwrite in   NUM_FWD_STAGES        regwrite flag per bypass stage
//  stage_rd       in   NUM_FWD_STAGES*REG_AW destination reg per stage, packed, stage i at [i*REG_AW +: REG_AW]
//  idex_rs        in   NUM_SRC*REG_AW        EX-stage source regs, packed
//  idex_rd        in   REG_AW                EX-stage destination
//  idex_regwrite  in   1                     EX-stage instruction writes rd
//  idex_memread   in   1                     EX-stage instruction is a load
//  ifid_rs        in   NUM_SRC*REG_AW        ID-stage source regs, packed
//  ifid_rs_used   in   NUM_SRC               per-source "operand actually read" mask
//  mc_issue_valid in   1                     multi-cycle op issuing from EX this cycle
//  mc_issue_rd    in   REG_AW                its destination register
//  mc_issue_lat   in   $clog2(MAX_LAT+1)     its latency in cycles
//  mc_issue_ready out  1                     issue accepted when valid & ready
//  forward_sel    out  NUM_SRC*FSW           per source: 0 = regfile, i+1 = stage i; FSW = $clog2(NUM_FWD_STAGES+1)
//  stall          out  1                     hold PC and IF/ID
//  bubble_idex    out  1                     insert NOP into ID/EX (== stall)
//  mc_wb_valid    out  1                     multi-cycle result writes back this cycle
//  mc_wb_rd       out  REG_AW                its destination register
// BEHAVIOUR
//  Reset:
//   - rst_n low clears all pending bits, counters and slot reservations immediately.
//   - Therefore mc_wb_valid=0, mc_wb_rd=0, mc_issue_ready=1.
//   - forward_sel and stall depend only on inputs and the cleared state.
//  Forwarding (combinational, 0-cycle latency):
//   - For source s, pick the lowest i with stage_regwrite[i] & stage_rd[i]==rs[s] & rs[s]!=0.
//     The youngest stage wins. If no stage matches, select 0.
//   - FWD_EN=0: forward_sel is tied to 0.
//  Stall (combinational from inputs and scoreboard state):
//   - Load-use: idex_memread & idex_regwrite & idex_rd!=0 & idex_rd matches any used ifid_rs.
//   - Scoreboard: any used, nonzero ifid_rs has its pending bit set.
//   - FWD_EN=0 only: any used ifid_rs matches idex_rd (when idex_regwrite) or any stage_rd[i]
//     (when stage_regwrite[i]).
//   - bubble_idex = stall.
//  Scoreboard, per register r: pending[r] plus cnt[r] (width $clog2(MAX_LAT+1)).
//   - Issue happens on mc_issue_valid & mc_issue_ready and rd!=0. It sets pending and loads cnt=lat.
//   - lat==0 is treated as 1. lat>MAX_LAT is treated as MAX_LAT.
//   - While pending, cnt decrements by 1 each cycle.
//   - When cnt==1: mc_wb_valid=1 and mc_wb_rd=r (registered outputs, valid that cycle).
//     pending[r] clears at the following edge.
//   - Issue with rd==0 is accepted. It creates no entry and produces no writeback.
//  Writeback slot reservation: slot vector of MAX_LAT bits, shifted down by 1 each cycle.
//   - Issue sets bit lat-1.
//   - mc_issue_ready = !pending[mc_issue_rd] & !slot[lat-1]. This blocks WAW on a pending reg
//     and blocks two completions in one cycle.
//   - Consequently at most one cnt==1 exists in any cycle.
//  Simultaneous events:
//   - Completion of r and a new issue to r in the same cycle: ready=0 (still pending). No overwrite.
//   - Completion of r and an ID read of r in the same cycle: still stalled. The read proceeds the
//     next cycle via the regfile.
//   - Stall and issue in the same cycle: the issue is still accepted (it comes from EX, which is not held).
//  Flush: no flush input. Issued multi-cycle ops always complete.
//  Mid-op reset: all state is dropped; no writeback pulse occurs.
// STRUCTURE
//  - Shared package: REG_AW, the FSW computation, the forward-select encoding constants
//    (FWD_REGFILE=0, FWD_STAGE_BASE=1).
//  - One sub-module, mc_scoreboard: holds pending, cnt, slot, issue_ready and the wb outputs.
//  - Forward-select and stall logic stay in the top module as generate loops over NUM_SRC and
//    NUM_FWD_STAGES.
// TESTING
//  1. stage0 rd=5 & stage1 rd=5, both regwrite, idex_rs[0]=5 -> forward_sel[0]=1.
//     Then rs=0 with the same stages -> 0.
//  2. Load idex_rd=7 with memread; ifid_rs[1]=7 used -> stall=bubble_idex=1 for one cycle.
//     With ifid_rs_used[1]=0 -> stall=0.
//  3. Issue rd=9 lat=4 at cycle T -> mc_wb_valid=1, mc_wb_rd=9 at T+4.
//     ifid_rs=9 stalls through T+4 and is released at T+5.
//  4. Issue lat=3 at T, then lat=2 at T+1 -> ready=0 at T+1 (slot clash).
//     Same issue retried with lat=3 at T+1 -> accepted, wb at T+3 and T+4.
//  5. Issue rd=9 while pending[9] -> ready=0. Assert rst_n=0 mid-count -> no wb pulse;
//     after release ready=1 and stall=0.
//  6. FWD_EN=0 build: stage1 rd=3 regwrite and ifid_rs=3 -> stall=1 and forward_sel all 0.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared sizing, forward-select encoding and latency helper for the hazard/forward controller.
package hazard_forward_ctrl_pkg;

  localparam int unsigned NUM_SRC        = 2;
  localparam int unsigned REG_AW         = 5;
  localparam int unsigned NUM_FWD_STAGES = 2;
  localparam int unsigned MAX_LAT        = 8;

  localparam int unsigned NUM_REGS = 2 ** REG_AW;
  localparam int unsigned FSW      = $clog2(NUM_FWD_STAGES + 1);
  localparam int unsigned LATW     = $clog2(MAX_LAT + 1);
  localparam int unsigned SLOTW    = $clog2(MAX_LAT);

  localparam logic [FSW-1:0] FWD_REGFILE    = FSW'(0);
  localparam logic [FSW-1:0] FWD_STAGE_BASE = FSW'(1);

  // Map a requested latency into the supported range 1..MAX_LAT.
  function automatic logic [LATW-1:0] clamp_lat(input logic [LATW-1:0] lat);
    if (lat == '0) begin
      return LATW'(1);
    end else if (lat > LATW'(MAX_LAT)) begin
      return LATW'(MAX_LAT);
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side signal bundle of the hazard/forward controller.
interface hazard_forward_ctrl_if;
  import hazard_forward_ctrl_pkg::*;

  logic [NUM_FWD_STAGES-1:0]        stage_regwrite;
  logic [NUM_FWD_STAGES*REG_AW-1:0] stage_rd;
  logic [NUM_SRC*REG_AW-1:0]        idex_rs;
  logic [REG_AW-1:0]                idex_rd;
  logic                             idex_regwrite;
  logic                             idex_memread;
  logic [NUM_SRC*REG_AW-1:0]        ifid_rs;
  logic [NUM_SRC-1:0]               ifid_rs_used;
  logic                             mc_issue_valid;
  logic [REG_AW-1:0]                mc_issue_rd;
  logic [LATW-1:0]                  mc_issue_lat;
  logic                             mc_issue_ready;
  logic [NUM_SRC*FSW-1:0]           forward_sel;
  logic                             stall;
  logic                             bubble_idex;
  logic                             mc_wb_valid;
  logic [REG_AW-1:0]                mc_wb_rd;

  modport master (
    output stage_regwrite, stage_rd, idex_rs, idex_rd, idex_regwrite, idex_memread,
           ifid_rs, ifid_rs_used, mc_issue_valid, mc_issue_rd, mc_issue_lat,
    input  mc_issue_ready, forward_sel, stall, bubble_idex, mc_wb_valid, mc_wb_rd
  );

  modport slave (
    input  stage_regwrite, stage_rd, idex_rs, idex_rd, idex_regwrite, idex_memread,
           ifid_rs, ifid_rs_used, mc_issue_valid, mc_issue_rd, mc_issue_lat,
    output mc_issue_ready, forward_sel, stall, bubble_idex, mc_wb_valid, mc_wb_rd
  );

endinterface

// File: rtl/hazard_forward_ctrl_mc_scoreboard.sv
// Per-register pending scoreboard and writeback-slot scheduler for the multi-cycle unit.
module hazard_forward_ctrl_mc_scoreboard
  import hazard_forward_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid_i,
  input  logic [REG_AW-1:0]   issue_rd_i,
  input  logic [LATW-1:0]     issue_lat_i,
  output logic                issue_ready_o,
  output logic                wb_valid_o,
  output logic [REG_AW-1:0]   wb_rd_o,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [LATW-1:0]     cnt_q [NUM_REGS];
  logic [LATW-1:0]     cnt_d [NUM_REGS];
  logic [MAX_LAT-1:0]  slot_q, slot_d;
  logic [MAX_LAT-1:0]  slot_res;
  logic                wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
  logic [LATW-1:0]     lat_eff;
  logic                alloc;

  // Issue is refused on WAW against a pending reg or when its completion cycle is already taken.
  assign lat_eff       = clamp_lat(issue_lat_i);
  assign issue_ready_o = !pending_q[issue_rd_i] && !slot_q[SLOTW'(lat_eff - LATW'(1))];
  assign alloc         = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  // Count down pending entries, allocate new ones, reserve slots and pick the next writeback.
  always_comb begin
    pending_d  = pending_q;
    slot_res   = '0;
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      cnt_d[r] = cnt_q[r];
      if (pending_q[r]) begin
        if (cnt_q[r] == LATW'(1)) begin
          pending_d[r] = 1'b0;
        end else begin
          cnt_d[r] = cnt_q[r] - LATW'(1);
        end
      end
    end
    if (alloc) begin
      pending_d[issue_rd_i] = 1'b1;
      cnt_d[issue_rd_i]     = lat_eff;
      slot_res              = MAX_LAT'(1) << (lat_eff - LATW'(1));
    end
    slot_d = (slot_q | slot_res) >> 1;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      if (pending_d[r] && (cnt_d[r] == LATW'(1))) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = REG_AW'(r);
      end
    end
  end

  // Scoreboard state; reset drops everything including an in-flight writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      slot_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      slot_q     <= slot_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign pending_o  = pending_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Operand bypass selection, load-use / scoreboard stall generation, multi-cycle scheduling.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_ctrl_if.slave  bus
);

  logic [NUM_REGS-1:0]         pending;
  logic [NUM_SRC-1:0]          src_hazard;
  logic [NUM_SRC-1:0][FSW-1:0] fwd_sel;
  logic                        stall_c;

  hazard_forward_ctrl_mc_scoreboard u_mc_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (bus.mc_issue_valid),
    .issue_rd_i    (bus.mc_issue_rd),
    .issue_lat_i   (bus.mc_issue_lat),
    .issue_ready_o (bus.mc_issue_ready),
    .wb_valid_o    (bus.mc_wb_valid),
    .wb_rd_o       (bus.mc_wb_rd),
    .pending_o     (pending)
  );

  for (genvar s = 0; s < int'(NUM_SRC); s++) begin : g_src
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] id_rs;
    logic [FSW-1:0]    sel;
    logic              hz;

    assign ex_rs = bus.idex_rs[s*REG_AW +: REG_AW];
    assign id_rs = bus.ifid_rs[s*REG_AW +: REG_AW];

    // Bypass select: scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
      sel = FWD_REGFILE;
      if (FWD_EN && (ex_rs != '0)) begin
        for (int i = int'(NUM_FWD_STAGES) - 1; i >= 0; i--) begin
          if (bus.stage_regwrite[i] && (bus.stage_rd[i*REG_AW +: REG_AW] == ex_rs)) begin
            sel = FWD_STAGE_BASE + FSW'(i);
          end
        end
      end
    end

    // Hazard on this ID operand: load-use, pending long-latency result, or any RAW without bypass.
    always_comb begin
      hz = 1'b0;
      if (bus.ifid_rs_used[s] && (id_rs != '0)) begin
        if (bus.idex_memread && bus.idex_regwrite && (bus.idex_rd == id_rs)) begin
          hz = 1'b1;
        end
        if (pending[id_rs]) begin
          hz = 1'b1;
        end
        if (!FWD_EN) begin
          if (bus.idex_regwrite && (bus.idex_rd == id_rs)) begin
            hz = 1'b1;
          end
          for (int i = 0; i < int'(NUM_FWD_STAGES); i++) begin
            if (bus.stage_regwrite[i] && (bus.stage_rd[i*REG_AW +: REG_AW] == id_rs)) begin
              hz = 1'b1;
            end
          end
        end
      end
    end

    assign fwd_sel[s]    = sel;
    assign src_hazard[s] = hz;
  end

  assign stall_c         = |src_hazard;
  assign bus.forward_sel = fwd_sel;
  assign bus.stall       = stall_c;
  assign bus.bubble_idex = stall_c;

endmodule
